// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scan-line inputs and recovered digit outputs of the 7-segment scan decoder
interface seg_scan_decoder_if;
  logic [3:0]  ds;
  logic [7:0]  seg;
  logic [19:0] vals;
  logic [3:0]  digit_valid;
  logic        update;
  logic [1:0]  update_idx;
  logic        glyph_err;

  modport master (
    output ds, seg,
    input  vals, digit_valid, update, update_idx, glyph_err
  );

  modport slave (
    input  ds, seg,
    output vals, digit_valid, update, update_idx, glyph_err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers four {DP, nibble} digits from a multiplexed 7-segment scan; SEGDEC_TIMEOUT_EN adds per-digit staleness timeout
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DS_ACTIVE_LOW  = 1'b1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic               clk,
  input logic               rst_n,
  seg_scan_decoder_if.slave bus
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  // An out-of-range parameter elaborates this visibly named empty block.
  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_out_of_range
  end

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  logic [3:0]    ds_s1, ds_s2;
  logic [7:0]    seg_s1, seg_s2;
  logic [3:0]    ds_n;
  logic [7:0]    seg_n;
  logic          one_hot;
  state_t        state_q, state_d;
  logic [3:0]    lat_ds_q, lat_ds_d;
  logic [7:0]    lat_seg_q, lat_seg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture;
  logic [3:0]    cap_sel;
  logic [1:0]    cap_idx;
  logic [4:0]    glyph;
  logic [19:0]   vals_q;
  logic [3:0]    valid_q;
  logic          update_q;
  logic [1:0]    idx_q;
  logic          err_q;
  logic [3:0]    expire;

  // Maps an active-high gfedcba pattern to {hit, nibble}; hit=0 for anything else, blank included.
  function automatic logic [4:0] decode_glyph(input logic [6:0] p);
    case (p)
      7'h3F:   decode_glyph = {1'b1, 4'h0};
      7'h06:   decode_glyph = {1'b1, 4'h1};
      7'h5B:   decode_glyph = {1'b1, 4'h2};
      7'h4F:   decode_glyph = {1'b1, 4'h3};
      7'h66:   decode_glyph = {1'b1, 4'h4};
      7'h6D:   decode_glyph = {1'b1, 4'h5};
      7'h7D:   decode_glyph = {1'b1, 4'h6};
      7'h07:   decode_glyph = {1'b1, 4'h7};
      7'h7F:   decode_glyph = {1'b1, 4'h8};
      7'h6F:   decode_glyph = {1'b1, 4'h9};
      7'h77:   decode_glyph = {1'b1, 4'hA};
      7'h7C:   decode_glyph = {1'b1, 4'hB};
      7'h39:   decode_glyph = {1'b1, 4'hC};
      7'h5E:   decode_glyph = {1'b1, 4'hD};
      7'h79:   decode_glyph = {1'b1, 4'hE};
      7'h71:   decode_glyph = {1'b1, 4'hF};
      default: decode_glyph = 5'b0;
    endcase
  endfunction

  // Two-stage synchronizer on the raw pad lines; no reset needed, reset clears everything downstream.
  always_ff @(posedge clk) begin
    ds_s1  <= bus.ds;
    ds_s2  <= ds_s1;
    seg_s1 <= bus.seg;
    seg_s2 <= seg_s1;
  end

  assign ds_n    = DS_ACTIVE_LOW  ? ~ds_s2  : ds_s2;
  assign seg_n   = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;
  assign one_hot = (ds_n != 4'b0) && ((ds_n & (ds_n - 4'd1)) == 4'b0);
  assign glyph   = decode_glyph(seg_n[6:0]);
  assign cap_sel = capture ? ds_n : 4'b0;

  // Index of the selected digit; only meaningful while ds_n is one-hot.
  always_comb begin
    cap_idx = 2'd0;
    case (ds_n)
      4'b0010: cap_idx = 2'd1;
      4'b0100: cap_idx = 2'd2;
      4'b1000: cap_idx = 2'd3;
      default: cap_idx = 2'd0;
    endcase
  end

  // Scan-tracking FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_ds_q  <= 4'b0;
      lat_seg_q <= 8'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lat_ds_q  <= lat_ds_d;
      lat_seg_q <= lat_seg_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state: wait for a lone strobe, require it stable for SETTLE_CYCLES samples, then capture once.
  always_comb begin
    state_d   = state_q;
    lat_ds_d  = lat_ds_q;
    lat_seg_d = lat_seg_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot) begin
          lat_ds_d  = ds_n;
          lat_seg_d = seg_n;
          cnt_d     = CW'(1);
          if (SETTLE_CYCLES == 1) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (ds_n != lat_ds_q || seg_n != lat_seg_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(SETTLE_CYCLES)) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Segment changes are driver ghosting here; only a strobe change ends the period.
        if (ds_n != lat_ds_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SEGDEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q [4];

  // Per-digit refresh age, cleared on any capture of that digit and saturating at the timeout.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || cap_sel[i]) begin
        tmo_q[i] <= '0;
      end else if (tmo_q[i] != TW'(TIMEOUT_CYCLES)) begin
        tmo_q[i] <= tmo_q[i] + TW'(1);
      end
    end
  end

  // A digit expires on the edge its age reaches the timeout, unless it is captured on that edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      expire[i] = !cap_sel[i] && (tmo_q[i] >= TW'(TIMEOUT_CYCLES - 1));
    end
  end
`else
  assign expire = 4'b0;
`endif

  // Captured values, validity and single-cycle result pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vals_q   <= 20'b0;
      valid_q  <= 4'b0;
      update_q <= 1'b0;
      idx_q    <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      update_q <= capture && glyph[4];
      err_q    <= capture && !glyph[4];
      if (capture && glyph[4]) begin
        idx_q <= cap_idx;
      end
      for (int i = 0; i < 4; i++) begin
        if (expire[i]) begin
          valid_q[i] <= 1'b0;
        end
        if (cap_sel[i]) begin
          valid_q[i] <= glyph[4];
          if (glyph[4]) begin
            vals_q[5*i +: 5] <= {seg_n[7], glyph[3:0]};
          end
        end
      end
    end
  end

  assign bus.vals        = vals_q;
  assign bus.digit_valid = valid_q;
  assign bus.update      = update_q;
  assign bus.update_idx  = idx_q;
  assign bus.glyph_err   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - randomized scan stimulus checked every cycle against a behavioural decoder model
module tb_seg_scan_decoder;
  localparam int SC = 4;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(
    .SETTLE_CYCLES (SC),
    .SEG_ACTIVE_LOW(1'b1),
    .DS_ACTIVE_LOW (1'b1),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pattern table search, spec-level idle/settle/hold bookkeeping.
  function automatic int lookup(input logic [6:0] p);
    for (int j = 0; j < 16; j++) if (glyph[j] == p) return j;
    return -1;
  endfunction

  logic [3:0]  p1_ds = 4'h0, p2_ds = 4'h0;
  logic [7:0]  p1_seg = 8'h0, p2_seg = 8'h0;
  int          m_mode = 0;
  int          m_run = 0;
  logic [3:0]  m_ds;
  logic [7:0]  m_seg;
  logic [19:0] e_vals = '0;
  logic [3:0]  e_valid = '0;
  logic        e_upd = 1'b0, e_err = 1'b0;
  logic [1:0]  e_idx = '0;
  longint      edge_n = 0;
  longint      last_cap [4];

  task automatic m_capture(input logic [3:0] d, input logic [7:0] s);
    int i;
    int g;
    i = 0;
    for (int k = 0; k < 4; k++) if (d[k]) i = k;
    g = lookup(s[6:0]);
    last_cap[i] = edge_n;
    if (g >= 0) begin
      e_vals[5*i +: 5] = {s[7], 4'(g)};
      e_valid[i] = 1'b1;
      e_upd = 1'b1;
      e_idx = 2'(i);
    end else begin
      e_valid[i] = 1'b0;
      e_err = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] s_ds;
    logic [7:0] s_seg;
    s_ds   = ~p2_ds;
    s_seg  = ~p2_seg;
    p2_ds  = p1_ds;
    p2_seg = p1_seg;
    p1_ds  = bus.ds;
    p1_seg = bus.seg;
    edge_n++;
    e_upd = 1'b0;
    e_err = 1'b0;
    if (!rst_n) begin
      e_vals  = '0;
      e_valid = '0;
      e_idx   = '0;
      m_mode  = 0;
      m_run   = 0;
      for (int i = 0; i < 4; i++) last_cap[i] = edge_n;
    end else begin
`ifdef SEGDEC_TIMEOUT_EN
      for (int i = 0; i < 4; i++) if (edge_n - last_cap[i] >= TO) e_valid[i] = 1'b0;
`endif
      if (m_mode == 0) begin
        if ($countones(s_ds) == 1) begin
          m_ds  = s_ds;
          m_seg = s_seg;
          m_run = 1;
          m_mode = 1;
          if (m_run == SC) begin m_capture(s_ds, s_seg); m_mode = 2; end
        end
      end else if (m_mode == 1) begin
        if (s_ds != m_ds || s_seg != m_seg) m_mode = 0;
        else begin
          m_run++;
          if (m_run == SC) begin m_capture(s_ds, s_seg); m_mode = 2; end
        end
      end else begin
        if (s_ds != m_ds) m_mode = 0;
      end
    end
  end

  int upd_total = 0;
  int err_total = 0;

  // Compare process: DUT outputs against the model every cycle, away from the edge.
  always @(posedge clk) begin
    #1;
    upd_total += int'(bus.update);
    err_total += int'(bus.glyph_err);
    check("vals", bus.vals, e_vals);
    check("digit_valid", bus.digit_valid, e_valid);
    check("update", bus.update, e_upd);
    check("glyph_err", bus.glyph_err, e_err);
    check("update_idx", bus.update_idx, e_idx);
    check("pulse_excl", bus.update & bus.glyph_err, 1'b0);
  end

  task automatic drive(input logic [3:0] sel, input logic [7:0] lit, input int n);
    bus.ds  = ~sel;
    bus.seg = ~lit;
    repeat (n) @(negedge clk);
  endtask

  int u0, g0, r, n1;
  logic [3:0] sel;
  logic [7:0] lit;

  initial begin
    rst_n   = 1'b0;
    bus.ds  = 4'hF;
    bus.seg = 8'hFF;
    repeat (2) begin
      bus.ds  = 4'($urandom);
      bus.seg = 8'($urandom);
      @(negedge clk);
    end
    check("reset_vals", bus.vals, 20'h0);
    check("reset_valid", bus.digit_valid, 4'h0);
    check("reset_update", bus.update, 1'b0);
    check("reset_glyph_err", bus.glyph_err, 1'b0);
    rst_n = 1'b1;
    drive(4'b0000, 8'h00, 5);

    u0 = upd_total;
    drive(4'b0001, {1'b1, glyph[0]}, 64);
    drive(4'b0010, {1'b0, glyph[2]}, 64);
    drive(4'b0100, {1'b0, glyph[4]}, 64);
    drive(4'b1000, {1'b0, glyph[8]}, 64);
    drive(4'b0000, 8'h00, 10);
    check("scan_updates", upd_total - u0, 4);
    check("scan_vals", bus.vals, 20'h41050);
    check("scan_valid", bus.digit_valid, 4'hF);

    u0 = upd_total;
    drive(4'b0001, 8'h7F, SC - 1);
    drive(4'b0000, 8'h7F, 10);
    check("short_strobe_updates", upd_total - u0, 0);
    check("short_strobe_vals", bus.vals, 20'h41050);

    g0 = err_total;
    drive(4'b0010, 8'h2A, 20);
    drive(4'b0000, 8'h00, 10);
    check("bad_glyph_errs", err_total - g0, 1);
    check("bad_glyph_valid", bus.digit_valid, 4'hD);
    check("bad_glyph_vals", bus.vals, 20'h41050);

    u0 = upd_total;
    g0 = err_total;
    drive(4'b0011, {1'b0, glyph[5]}, 100);
    drive(4'b0000, 8'h00, 5);
    check("multi_hot_updates", upd_total - u0, 0);
    check("multi_hot_errs", err_total - g0, 0);

`ifdef SEGDEC_TIMEOUT_EN
    drive(4'b1000, {1'b0, glyph[5]}, 20);
    drive(4'b0000, 8'h00, TO + 10);
    check("timeout_valid3", bus.digit_valid[3], 1'b0);
    check("timeout_vals3", bus.vals[19:15], 5'h05);
    drive(4'b1000, {1'b0, glyph[5]}, 20);
    drive(4'b0000, 8'h00, 5);
    check("rescan_valid3", bus.digit_valid[3], 1'b1);
`endif

    for (int k = 0; k < 400; k++) begin
      r   = $urandom_range(0, 19);
      sel = 4'b0001 << $urandom_range(0, 3);
      lit = {1'($urandom), 1'b0, glyph[$urandom_range(0, 15)]};
      n1  = $urandom_range(1, 12);
      if (r == 0) begin
        rst_n = 1'b0;
        drive(sel, lit, 2);
        rst_n = 1'b1;
      end else if (r < 3) begin
        drive(4'($urandom), 8'($urandom), n1);
      end else if (r < 5) begin
        drive(sel, 8'($urandom), n1);
      end else if (r < 7) begin
        drive(sel, lit, n1);
        drive(sel, lit ^ 8'($urandom_range(1, 255)), $urandom_range(1, 8));
      end else begin
        drive(sel, lit, n1);
      end
      if ($urandom_range(0, 2) == 0) drive(4'b0000, 8'($urandom), $urandom_range(1, 3));
    end
    drive(4'b0000, 8'h00, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
